// File: rtl/ysyx_22041752_stage_fifo.sv
// Inter-stage valid/allowin buffer: DEPTH-entry queue between two pipeline stages,
// with redirect flush and optional same-cycle bypass when empty.
module ysyx_22041752_stage_fifo #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic [WIDTH-1:0]           in_bus,
  output logic                       out_valid,
  input  logic                       out_allowin,
  output logic [WIDTH-1:0]           out_bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int   PTR_W = $clog2(DEPTH);
  localparam int   CNT_W = $clog2(DEPTH + 1);
  localparam logic BYP   = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;
  logic bypass_hit;
  logic do_write;
  logic do_read;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // Handshake outputs are forced low while reset is held so neither side fires.
  assign in_allowin = reset & ~flush & (~full | out_allowin);
  assign out_valid  = reset & ~flush & (~empty | (BYP & in_valid));
  assign out_bus    = out_valid ? (empty ? in_bus : mem[rd_ptr]) : '0;

  assign push = in_valid & in_allowin;
  assign pop  = out_valid & out_allowin;

  // An empty bypassing queue hands the payload straight through: no storage touched.
  assign bypass_hit = BYP & empty & push & pop;
  assign do_write   = push & ~bypass_hit;
  assign do_read    = pop & ~bypass_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_write) - CNT_W'(do_read);
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= in_bus;
  end

endmodule

// File: tb/tb_ysyx_22041752_stage_fifo.sv
// Directed bench for the stage FIFO: a non-bypass and a bypass instance,
// each checked against a queue-based scoreboard of expected head values.
module tb_ysyx_22041752_stage_fifo;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;

  logic         flush, in_valid, out_allowin;
  logic         in_allowin, out_valid, full, empty;
  logic [W-1:0] in_bus, out_bus;
  logic [2:0]   count;

  logic         b_flush, b_in_valid, b_out_allowin;
  logic         b_in_allowin, b_out_valid, b_full, b_empty;
  logic [W-1:0] b_in_bus, b_out_bus;
  logic [2:0]   b_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  ysyx_22041752_stage_fifo #(.WIDTH(W), .DEPTH(4), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_bus(in_bus),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_bus(out_bus),
    .count(count), .full(full), .empty(empty)
  );

  ysyx_22041752_stage_fifo #(.WIDTH(W), .DEPTH(4), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_allowin(b_in_allowin), .in_bus(b_in_bus),
    .out_valid(b_out_valid), .out_allowin(b_out_allowin), .out_bus(b_out_bus),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Non-bypass instance: drive one cycle, check outputs before the edge, update scoreboard.
  task automatic tick0(input logic v, input logic [W-1:0] d, input logic oa, input logic fl);
    logic exp_allow, exp_ov;
    in_valid = v; in_bus = d; out_allowin = oa; flush = fl;
    #1;
    exp_allow = !fl && (q0.size() < 4 || oa);
    exp_ov    = !fl && (q0.size() != 0);
    check("in_allowin", in_allowin, exp_allow);
    check("out_valid", out_valid, exp_ov);
    check("out_bus", out_bus, exp_ov ? q0[0] : '0);
    check("count", count, q0.size());
    check("full", full, q0.size() == 4);
    check("empty", empty, q0.size() == 0);
    if (fl) q0.delete();
    else begin
      if (exp_ov && oa) void'(q0.pop_front());
      if (v && exp_allow) q0.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic tick1(input logic v, input logic [W-1:0] d, input logic oa, input logic fl);
    logic exp_allow, exp_ov;
    logic [W-1:0] exp_bus;
    b_in_valid = v; b_in_bus = d; b_out_allowin = oa; b_flush = fl;
    #1;
    exp_allow = !fl && (q1.size() < 4 || oa);
    exp_ov    = !fl && (q1.size() != 0 || v);
    exp_bus   = !exp_ov ? '0 : (q1.size() != 0 ? q1[0] : d);
    check("b_in_allowin", b_in_allowin, exp_allow);
    check("b_out_valid", b_out_valid, exp_ov);
    check("b_out_bus", b_out_bus, exp_bus);
    check("b_count", b_count, q1.size());
    check("b_empty", b_empty, q1.size() == 0);
    if (fl) q1.delete();
    else if (q1.size() == 0 && v && oa) begin
      // consumed directly by the bypass path
    end else begin
      if (exp_ov && oa) void'(q1.pop_front());
      if (v && exp_allow) q1.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    flush = 0; in_valid = 1; in_bus = 16'h77; out_allowin = 1;
    b_flush = 0; b_in_valid = 1; b_in_bus = 16'h88; b_out_allowin = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bus", out_bus, 0);
    check("rst_in_allowin", in_allowin, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_bus", b_out_bus, 0);
    check("rst_b_in_allowin", b_in_allowin, 0);
    b_in_valid = 0; b_out_allowin = 0;
    @(negedge clk);
    reset = 1'b1;

    // Fill to full with consumer stalled, then drain in order
    tick0(1, 16'hA1, 0, 0);
    tick0(1, 16'hA2, 0, 0);
    tick0(1, 16'hA3, 0, 0);
    tick0(1, 16'hA4, 0, 0);
    tick0(1, 16'hEE, 0, 0);
    for (int i = 0; i < 4; i++) tick0(0, 16'h0, 1, 0);
    tick0(0, 16'h0, 0, 0);

    // Full queue with simultaneous push and pop
    tick0(1, 16'hB1, 0, 0);
    tick0(1, 16'hB2, 0, 0);
    tick0(1, 16'hB3, 0, 0);
    tick0(1, 16'hB4, 0, 0);
    tick0(1, 16'hB5, 1, 0);
    for (int i = 0; i < 4; i++) tick0(0, 16'h0, 1, 0);
    tick0(0, 16'h0, 0, 0);

    // Pointer wrap with two entries resident
    tick0(1, 16'h10, 0, 0);
    tick0(1, 16'h11, 0, 0);
    for (int i = 0; i < 10; i++) tick0(1, W'(i), 1, 0);
    tick0(0, 16'h0, 1, 0);
    tick0(0, 16'h0, 1, 0);
    tick0(0, 16'h0, 0, 0);

    // Flush with three entries held
    tick0(1, 16'h51, 0, 0);
    tick0(1, 16'h52, 0, 0);
    tick0(1, 16'h53, 0, 0);
    tick0(1, 16'h54, 1, 1);
    tick0(1, 16'h66, 0, 0);
    tick0(0, 16'h0, 1, 0);
    tick0(0, 16'h0, 0, 0);

    // Asynchronous reset between edges with two entries held
    tick0(1, 16'h61, 0, 0);
    tick0(1, 16'h62, 0, 0);
    in_valid = 0; out_allowin = 0;
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    check("async_in_allowin", in_allowin, 0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b1;
    tick0(1, 16'hD7, 0, 0);
    tick0(0, 16'h0, 1, 0);
    tick0(0, 16'h0, 0, 0);

    // Bypass instance: same-cycle pass-through, then held when consumer stalls
    tick1(1, 16'hC3, 1, 0);
    tick1(0, 16'h0, 0, 0);
    tick1(1, 16'hC3, 0, 0);
    tick1(1, 16'hC4, 0, 0);
    tick1(0, 16'h0, 1, 0);
    tick1(0, 16'h0, 1, 0);
    tick1(0, 16'h0, 0, 0);
    tick1(1, 16'hC5, 1, 1);
    tick1(0, 16'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
